// File: rtl/rib_rr_arbiter.sv
// Registered round-robin bus arbiter for the RIB masters with a per-owner burst limit.
// The owner keeps the bus until it releases its request, or until BURST_MAX cycles pass while another master waits.
module rib_rr_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int BURST_MAX      = 16,
    parameter int DEFAULT_MASTER = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_MASTERS-1:0]         req_i,
    output logic [NUM_MASTERS-1:0]         grant_o,
    output logic [$clog2(NUM_MASTERS)-1:0] grant_id_o,
    output logic                           grant_valid_o,
    output logic                           hold_flag_o,
    output logic                           timeout_o,
    output logic                           dbg_own,
    output logic [$clog2(BURST_MAX)-1:0]   dbg_burst_cnt
);

    localparam int ID_W = $clog2(NUM_MASTERS);
    localparam int CNT_W = $clog2(BURST_MAX);
    localparam logic [ID_W-1:0] DEF_ID = ID_W'(DEFAULT_MASTER);
    localparam logic [ID_W-1:0] LAST_RST = ID_W'(NUM_MASTERS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX - 1);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t state, state_n;
    logic [ID_W-1:0] owner, owner_n, last_owner, last_n, pick_id, idx;
    logic [CNT_W-1:0] burst_cnt, cnt_n;
    logic pick_found, other_pending, timeout_n;
    logic [NUM_MASTERS-1:0] owner_mask, grant_n;
    logic [ID_W-1:0] grant_id_n;
    logic valid_n, hold_n;

    assign owner_mask    = NUM_MASTERS'(1) << owner;
    assign other_pending = |(req_i & ~owner_mask);
    assign dbg_own       = (state == OWN);
    assign dbg_burst_cnt = burst_cnt;

    // Scan from last_owner+1 upward; the current owner is never re-picked while it owns.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = last_owner;
        idx        = '0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            idx = ID_W'((int'(last_owner) + i) % NUM_MASTERS);
            if (!pick_found && req_i[idx] && !(state == OWN && idx == owner)) begin
                pick_found = 1'b1;
                pick_id    = idx;
            end
        end
    end

    always_comb begin
        state_n   = state;
        owner_n   = owner;
        last_n    = last_owner;
        cnt_n     = burst_cnt;
        timeout_n = 1'b0;
        case (state)
            IDLE: begin
                if (|req_i) begin
                    state_n = OWN;
                    owner_n = pick_id;
                    last_n  = pick_id;
                    cnt_n   = '0;
                end
            end
            OWN: begin
                if (!req_i[owner]) begin
                    cnt_n = '0;
                    if (other_pending) begin
                        owner_n = pick_id;
                        last_n  = pick_id;
                    end else begin
                        state_n = IDLE;
                    end
                end else if (burst_cnt == CNT_MAX && other_pending) begin
                    owner_n   = pick_id;
                    last_n    = pick_id;
                    cnt_n     = '0;
                    timeout_n = 1'b1;
                end else if (burst_cnt != CNT_MAX) begin
                    cnt_n = burst_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Output values are derived from the next state so every output leaves a flop.
    always_comb begin
        valid_n    = (state_n == OWN);
        grant_n    = valid_n ? (NUM_MASTERS'(1) << owner_n) : '0;
        grant_id_n = valid_n ? owner_n : DEF_ID;
        hold_n     = valid_n && (owner_n != DEF_ID);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            owner         <= DEF_ID;
            last_owner    <= LAST_RST;
            burst_cnt     <= '0;
            grant_o       <= '0;
            grant_id_o    <= DEF_ID;
            grant_valid_o <= 1'b0;
            hold_flag_o   <= 1'b0;
            timeout_o     <= 1'b0;
        end else begin
            state         <= state_n;
            owner         <= owner_n;
            last_owner    <= last_n;
            burst_cnt     <= cnt_n;
            grant_o       <= grant_n;
            grant_id_o    <= grant_id_n;
            grant_valid_o <= valid_n;
            hold_flag_o   <= hold_n;
            timeout_o     <= timeout_n;
        end
    end

endmodule

// File: tb/tb_rib_rr_arbiter.sv
// Bench for rib_rr_arbiter: directed scenarios plus held random request patterns,
// every cycle compared against a behavioural round-robin model.
module tb_rib_rr_arbiter;

    localparam int N  = 4;
    localparam int BM = 16;
    localparam int DM = 1;
    localparam int IW = 2;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_i;
    logic [N-1:0]  grant_o;
    logic [IW-1:0] grant_id_o;
    logic          grant_valid_o, hold_flag_o, timeout_o, dbg_own;
    logic [CW-1:0] dbg_burst_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rib_rr_arbiter #(.NUM_MASTERS(N), .BURST_MAX(BM), .DEFAULT_MASTER(DM)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .grant_o(grant_o), .grant_id_o(grant_id_o),
        .grant_valid_o(grant_valid_o), .hold_flag_o(hold_flag_o), .timeout_o(timeout_o),
        .dbg_own(dbg_own), .dbg_burst_cnt(dbg_burst_cnt)
    );

    // Reference model: who owns the bus, for how long, and who was served last.
    bit   m_valid = 1'b0;
    int   m_owner = DM;
    int   m_last  = N - 1;
    int   m_cnt   = 0;
    bit   m_timeout = 1'b0;
    int   m_held  = 0;
    logic [N-1:0] exp_q[$];

    function automatic logic [N-1:0] bitmask(input int i);
        return N'(1) << i;
    endfunction

    function automatic int rr_pick(input logic [N-1:0] req);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_last + k) % N;
            if ((req & bitmask(c)) != 0) return c;
        end
        return -1;
    endfunction

    task automatic model_update(input logic [N-1:0] req, input bit r);
        logic [N-1:0] others;
        logic [N-1:0] g;
        int prev_owner;
        bit prev_valid;
        prev_owner = m_owner;
        prev_valid = m_valid;
        m_timeout  = 1'b0;
        if (r) begin
            m_valid = 1'b0;
            m_last  = N - 1;
            m_cnt   = 0;
        end else if (!m_valid) begin
            if (req != 0) begin
                m_owner = rr_pick(req);
                m_last  = m_owner;
                m_valid = 1'b1;
                m_cnt   = 0;
            end
        end else begin
            others = req & ~bitmask(m_owner);
            if ((req & bitmask(m_owner)) == 0) begin
                m_cnt = 0;
                if (others != 0) begin
                    m_owner = rr_pick(others);
                    m_last  = m_owner;
                end else begin
                    m_valid = 1'b0;
                end
            end else if (m_cnt == BM - 1 && others != 0) begin
                m_owner   = rr_pick(others);
                m_last    = m_owner;
                m_cnt     = 0;
                m_timeout = 1'b1;
            end else if (m_cnt < BM - 1) begin
                m_cnt++;
            end
        end
        if (!m_valid) m_held = 0;
        else if (!prev_valid || prev_owner != m_owner || m_timeout) m_held = 1;
        else m_held++;
        g = m_valid ? bitmask(m_owner) : '0;
        exp_q.push_back(g);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, update model on the edge, sample 1 time unit later.
    task automatic step(input logic [N-1:0] req, input bit do_rst);
        logic [N-1:0] exp_g;
        @(negedge clk);
        req_i = req;
        rst   = do_rst;
        @(posedge clk);
        model_update(req, do_rst);
        #1;
        exp_g = exp_q.pop_front();
        check("grant_o", 32'(grant_o), 32'(exp_g));
        check("grant_id_o", 32'(grant_id_o), m_valid ? m_owner : DM);
        check("grant_valid_o", 32'(grant_valid_o), 32'(m_valid));
        check("hold_flag_o", 32'(hold_flag_o), 32'(m_valid && m_owner != DM));
        check("timeout_o", 32'(timeout_o), 32'(m_timeout));
        check("burst_cnt", 32'(dbg_burst_cnt), m_cnt);
        check("dbg_own", 32'(dbg_own), 32'(m_valid));
    endtask

    task automatic do_reset(input logic [N-1:0] req);
        step(req, 1'b1);
        step(req, 1'b1);
    endtask

    initial begin
        int order[$];
        int exp_order[5];
        int idle_cycles;
        int pulses;
        int own_cycles;
        bit moved;
        logic [N-1:0] r;
        int len;

        rst   = 1'b1;
        req_i = '0;
        exp_order = '{0, 1, 2, 3, 0};

        // Reset with all requests held; master 0 wins first.
        do_reset(4'b1111);
        check("rst_grant_o", 32'(grant_o), 0);
        check("rst_grant_id", 32'(grant_id_o), DM);
        step(4'b1111, 1'b0);
        check("first_id", 32'(grant_id_o), 0);
        check("first_grant", 32'(grant_o), 32'h1);
        check("first_hold", 32'(hold_flag_o), 1);

        // Each owner releases after 3 owned cycles: 0,1,2,3,0 with no idle gap.
        order.push_back(int'(grant_id_o));
        idle_cycles = 0;
        for (int i = 0; i < 14; i++) begin
            r = 4'b1111;
            if (m_valid && m_held == 3) r = r & ~bitmask(m_owner);
            step(r, 1'b0);
            if (!grant_valid_o) idle_cycles++;
            else if (order[order.size()-1] != int'(grant_id_o)) order.push_back(int'(grant_id_o));
        end
        check("rr_idle_cycles", idle_cycles, 0);
        for (int i = 0; i < 5; i++)
            check("rr_order", (i < order.size()) ? order[i] : -1, exp_order[i]);

        // Sole requester keeps the bus for good.
        do_reset(4'b0000);
        pulses = 0;
        own_cycles = 0;
        for (int i = 0; i < 100; i++) begin
            step(4'b0100, 1'b0);
            if (timeout_o) pulses++;
            if (grant_valid_o && grant_id_o == 2'd2 && hold_flag_o) own_cycles++;
        end
        check("sole_timeouts", pulses, 0);
        check("sole_owned", own_cycles, 100);

        // Forced rotation after BM owned cycles while master 3 waits.
        do_reset(4'b0000);
        step(4'b0001, 1'b0);
        own_cycles = (grant_id_o == 2'd0 && grant_valid_o) ? 1 : 0;
        pulses = 0;
        moved = 1'b0;
        for (int i = 0; i < 40 && !moved; i++) begin
            step(4'b1001, 1'b0);
            if (timeout_o) pulses++;
            if (grant_valid_o && grant_id_o == 2'd3) begin
                moved = 1'b1;
                check("rot_pulse_at_move", 32'(timeout_o), 1);
            end else if (grant_valid_o && grant_id_o == 2'd0) begin
                own_cycles++;
            end
        end
        check("rot_reached", 32'(moved), 1);
        check("rot_owned_cycles", own_cycles, BM);
        for (int i = 0; i < 3; i++) begin
            step(4'b1001, 1'b0);
            if (timeout_o) pulses++;
        end
        check("rot_pulses", pulses, 1);

        // Default master alone: no stall; release returns to idle.
        do_reset(4'b0000);
        step(4'b0010, 1'b0);
        check("dm_id", 32'(grant_id_o), 1);
        check("dm_valid", 32'(grant_valid_o), 1);
        check("dm_hold", 32'(hold_flag_o), 0);
        step(4'b0000, 1'b0);
        check("dm_idle_grant", 32'(grant_o), 0);
        check("dm_idle_valid", 32'(grant_valid_o), 0);

        // Reset in the middle of master 2's burst.
        do_reset(4'b0000);
        for (int i = 0; i < 5; i++) step(4'b0100, 1'b0);
        step(4'b0100, 1'b1);
        check("mid_rst_grant", 32'(grant_o), 0);
        check("mid_rst_cnt", 32'(dbg_burst_cnt), 0);
        check("mid_rst_timeout", 32'(timeout_o), 0);
        step(4'b0000, 1'b0);
        step(4'b1111, 1'b0);
        check("post_rst_id", 32'(grant_id_o), 0);

        // Random request patterns held for random lengths, with occasional resets.
        for (int seg = 0; seg < 60; seg++) begin
            r   = N'($urandom_range(0, (1 << N) - 1));
            len = $urandom_range(1, 24);
            if ($urandom_range(0, 29) == 0) step(r, 1'b1);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 7) == 0) r = r ^ bitmask($urandom_range(0, N - 1));
                step(r, 1'b0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
